// File: rtl/matbi_stream_pkg.sv
// Shared types and constants for the matbi stream scaler.
// Lane layout: 8 unsigned byte lanes per 64-bit stream word.
package matbi_stream_pkg;

    localparam int LANES  = 8;
    localparam int LANE_W = 8;
    localparam int CNT_W  = 30;

    typedef logic [LANE_W-1:0]       lane_t;
    typedef logic [LANES*LANE_W-1:0] word_t;
    typedef logic [CNT_W-1:0]        cnt_t;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    // Widen to 33 bits so that byte counts near 2^32 round up without wrapping.
    function automatic cnt_t words_of(input logic [31:0] bytes);
        logic [32:0] sum;
        sum = {1'b0, bytes} + 33'd7;
        return cnt_t'(sum >> 3);
    endfunction

endpackage

// File: rtl/matbi_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Head reads as zero while empty so the output is clean after reset.
module matbi_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty_n,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty_n = (count != '0);
    assign do_pop  = pop && empty_n;
    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    assign do_push = push && ((count != FULL_CNT) || do_pop);
    assign dout    = empty_n ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/matbi_stream_scaler.sv
// Per-lane affine byte scaler between RDMA and WDMA streams: y = ((x*gain)>>shift)+bias.
// Define MATBI_SCALER_SAT_EN to clamp lane results at 0xFF instead of wrapping.
module matbi_stream_scaler
    import matbi_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  ap_clk,
    input  logic                  areset,
    input  logic                  ap_start,
    output logic                  ap_idle,
    output logic                  ap_done,
    output logic                  ap_ready,
    input  logic [31:0]           transfer_byte,
    input  logic [7:0]            gain,
    input  logic [2:0]            shift,
    input  logic [7:0]            bias,
    input  logic [DATA_WIDTH-1:0] in_r_din,
    output logic                  in_r_full_n,
    input  logic                  in_r_write,
    output logic [DATA_WIDTH-1:0] out_r_dout,
    output logic                  out_r_empty_n,
    input  logic                  out_r_read
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 2;
`ifdef MATBI_SCALER_SAT_EN
    localparam int R_W = 17;
`else
    localparam int R_W = LANE_W;
`endif

    state_t        state;
    state_t        next_state;
    lane_t         gain_q;
    lane_t         bias_q;
    logic [2:0]    shift_q;
    cnt_t          words_q;
    cnt_t          acc_cnt;
    cnt_t          pop_cnt;
    cnt_t          acc_inc;
    cnt_t          pop_inc;
    cnt_t          job_words;
    logic          accept;
    logic          popped;
    logic          s1_valid;
    logic          s2_valid;
    logic [AW:0]   fifo_count;
    logic [OW-1:0] inflight;
    word_t         push_data;

    assign job_words = words_of(transfer_byte);
    assign acc_inc   = acc_cnt + 1'b1;
    assign pop_inc   = pop_cnt + 1'b1;
    assign accept    = in_r_write && in_r_full_n;
    assign popped    = out_r_read && out_r_empty_n;

    // Words already in the pipeline are reserved FIFO slots, so full_n can never overflow it.
    assign inflight    = OW'(fifo_count) + OW'(s1_valid) + OW'(s2_valid);
    assign in_r_full_n = (state == S_RUN) && (inflight < OW'(FIFO_DEPTH));

    assign ap_idle  = (state == S_IDLE);
    assign ap_done  = (state == S_DONE);
    assign ap_ready = (state == S_DONE);

    always_ff @(posedge ap_clk) begin
        if (areset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (ap_start) next_state = (job_words == '0) ? S_DONE : S_RUN;
            S_RUN:   if (accept && (acc_inc == words_q)) next_state = S_DRAIN;
            S_DRAIN: if ((pop_cnt == words_q) || (popped && (pop_inc == words_q)))
                         next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            gain_q  <= '0;
            shift_q <= '0;
            bias_q  <= '0;
            words_q <= '0;
            acc_cnt <= '0;
            pop_cnt <= '0;
        end else if (state == S_IDLE && ap_start) begin
            gain_q  <= gain;
            shift_q <= shift;
            bias_q  <= bias;
            words_q <= job_words;
            acc_cnt <= '0;
            pop_cnt <= '0;
        end else begin
            if (accept) acc_cnt <= acc_inc;
            if (popped) pop_cnt <= pop_inc;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        lane_t          x;
        logic [15:0]    p;
        logic [R_W-1:0] r;
        lane_t          y;

        assign x = in_r_din[l*LANE_W +: LANE_W];

        always_ff @(posedge ap_clk) begin
            if (areset) begin
                p <= '0;
                r <= '0;
            end else begin
                if (accept)   p <= 16'(x) * 16'(gain_q);
                if (s1_valid) r <= R_W'(p >> shift_q) + R_W'(bias_q);
            end
        end

`ifdef MATBI_SCALER_SAT_EN
        assign y = (r > R_W'(255)) ? 8'hFF : r[7:0];
`else
        assign y = r;
`endif

        assign push_data[l*LANE_W +: LANE_W] = y;
    end

    matbi_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (ap_clk),
        .areset  (areset),
        .push    (s2_valid),
        .din     (push_data),
        .pop     (out_r_read),
        .dout    (out_r_dout),
        .empty_n (out_r_empty_n),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_matbi_stream_scaler.sv
// Directed self-checking bench for matbi_stream_scaler with a queue scoreboard.
// Honours MATBI_SCALER_SAT_EN the same way the design does.
module tb_matbi_stream_scaler;

    logic        ap_clk = 1'b0;
    logic        areset = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_idle;
    logic        ap_done;
    logic        ap_ready;
    logic [31:0] transfer_byte = '0;
    logic [7:0]  gain = '0;
    logic [2:0]  shift = '0;
    logic [7:0]  bias = '0;
    logic [63:0] in_r_din = '0;
    logic        in_r_full_n;
    logic        in_r_write = 1'b0;
    logic [63:0] out_r_dout;
    logic        out_r_empty_n;
    logic        out_r_read = 1'b0;

    logic [63:0] sb_q[$];
    logic [63:0] popped_q[$];
    int          errors = 0;
    int          checks = 0;
    int          accepted = 0;
    int          pops = 0;
    int          max_depth = 0;
    int          m_gain = 0;
    int          m_shift = 0;
    int          m_bias = 0;
    logic        s_full_n, s_empty_n, s_done, s_ready, s_idle;
    logic [63:0] s_dout;

    always #5 ap_clk = ~ap_clk;

    matbi_stream_scaler dut (
        .ap_clk        (ap_clk),
        .areset        (areset),
        .ap_start      (ap_start),
        .ap_idle       (ap_idle),
        .ap_done       (ap_done),
        .ap_ready      (ap_ready),
        .transfer_byte (transfer_byte),
        .gain          (gain),
        .shift         (shift),
        .bias          (bias),
        .in_r_din      (in_r_din),
        .in_r_full_n   (in_r_full_n),
        .in_r_write    (in_r_write),
        .out_r_dout    (out_r_dout),
        .out_r_empty_n (out_r_empty_n),
        .out_r_read    (out_r_read)
    );

    function automatic logic [63:0] modelWord(input logic [63:0] x);
        logic [63:0] y;
        int r;
        y = '0;
        for (int l = 0; l < 8; l++) begin
            r = ((int'(x[l*8 +: 8]) * m_gain) >> m_shift) + m_bias;
`ifdef MATBI_SCALER_SAT_EN
            if (r > 255) r = 255;
`endif
            y[l*8 +: 8] = r[7:0];
        end
        return y;
    endfunction

    task checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock: drive at posedge+1, sample at negedge, score accepted writes and pops.
    task applyStimulus(input logic wr, input logic [63:0] d, input logic rd);
        in_r_write = wr;
        in_r_din   = d;
        out_r_read = rd;
        @(negedge ap_clk);
        s_full_n  = in_r_full_n;
        s_empty_n = out_r_empty_n;
        s_done    = ap_done;
        s_ready   = ap_ready;
        s_idle    = ap_idle;
        s_dout    = out_r_dout;
        if (wr && in_r_full_n) begin
            sb_q.push_back(modelWord(d));
            accepted++;
        end
        if (rd && out_r_empty_n) begin
            pops++;
            popped_q.push_back(out_r_dout);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_underflow observed=0x%0h expected=none", out_r_dout);
            end else begin
                checkOutput("dout", out_r_dout, sb_q.pop_front());
            end
        end
        if (sb_q.size() > max_depth) max_depth = sb_q.size();
        @(posedge ap_clk);
        #1;
    endtask

    task startJob(input logic [31:0] nbytes, input logic [7:0] g, input logic [2:0] s,
                  input logic [7:0] b);
        transfer_byte = nbytes;
        gain = g;
        shift = s;
        bias = b;
        m_gain = int'(g);
        m_shift = int'(s);
        m_bias = int'(b);
        accepted = 0;
        pops = 0;
        max_depth = 0;
        popped_q.delete();
        ap_start = 1'b1;
        applyStimulus(1'b0, 64'd0, 1'b0);
        ap_start = 1'b0;
    endtask

    task waitDone(input string tag, input int limit);
        for (int n = 0; n < limit; n++) begin
            applyStimulus(1'b0, 64'd0, 1'b1);
            if (s_done) break;
        end
        checkOutput(tag, 64'(s_done), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int n;
        logic done_any;
        logic [63:0] sat_exp;

        applyStimulus(1'b0, 64'd0, 1'b0);
        applyStimulus(1'b0, 64'd0, 1'b0);
        checkOutput("rst_idle", 64'(s_idle), 64'd1);
        checkOutput("rst_done", 64'(s_done), 64'd0);
        checkOutput("rst_ready", 64'(s_ready), 64'd0);
        checkOutput("rst_full_n", 64'(s_full_n), 64'd0);
        checkOutput("rst_empty_n", 64'(s_empty_n), 64'd0);
        checkOutput("rst_dout", s_dout, 64'd0);
        areset = 1'b0;
        applyStimulus(1'b0, 64'd0, 1'b0);

        $display("[TB] basic job");
        startJob(32'd16, 8'd2, 3'd1, 8'd3);
        applyStimulus(1'b1, 64'h0807060504030201, 1'b1);
        applyStimulus(1'b1, 64'h100F0E0D0C0B0A09, 1'b1);
        n = 0;
        while (pops < 2 && n < 10) begin
            applyStimulus(1'b0, 64'd0, 1'b1);
            n++;
        end
        checkOutput("t1_pops", 64'(pops), 64'd2);
        applyStimulus(1'b0, 64'd0, 1'b0);
        checkOutput("t1_done", 64'(s_done), 64'd1);
        checkOutput("t1_ready", 64'(s_ready), 64'd1);
        checkOutput("t1_busy", 64'(s_idle), 64'd0);
        applyStimulus(1'b0, 64'd0, 1'b0);
        checkOutput("t1_idle", 64'(s_idle), 64'd1);
        checkOutput("t1_done_low", 64'(s_done), 64'd0);
        checkOutput("t1_word0", popped_q[0], 64'h0B0A090807060504);
        checkOutput("t1_word1", popped_q[1], 64'h131211100F0E0D0C);

        $display("[TB] zero length");
        startJob(32'd0, 8'd1, 3'd0, 8'd0);
        applyStimulus(1'b1, 64'hAA, 1'b0);
        checkOutput("t2_zero_done", 64'(s_done), 64'd1);
        applyStimulus(1'b1, 64'hBB, 1'b0);
        checkOutput("t2_zero_idle", 64'(s_idle), 64'd1);
        checkOutput("t2_zero_acc", 64'(accepted), 64'd0);

        $display("[TB] partial length");
        startJob(32'd9, 8'd1, 3'd0, 8'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 64'h1111_0000_0000_0000 + 64'(i), 1'b1);
            if (s_done) break;
        end
        checkOutput("t2_part_done", 64'(s_done), 64'd1);
        checkOutput("t2_part_acc", 64'(accepted), 64'd2);
        checkOutput("t2_part_sb", 64'(sb_q.size()), 64'd0);
        applyStimulus(1'b0, 64'd0, 1'b0);

        $display("[TB] backpressure");
        startJob(32'd160, 8'd3, 3'd2, 8'd5);
        for (int i = 0; i < 25; i++) applyStimulus(1'b1, {$urandom, $urandom}, 1'b0);
        checkOutput("t3_acc16", 64'(accepted), 64'd16);
        checkOutput("t3_full_n_low", 64'(s_full_n), 64'd0);
        n = 0;
        while (pops < 16 && n < 30) begin
            applyStimulus(1'b0, 64'd0, 1'b1);
            n++;
        end
        checkOutput("t3_pops16", 64'(pops), 64'd16);
        applyStimulus(1'b0, 64'd0, 1'b0);
        checkOutput("t3_full_n_high", 64'(s_full_n), 64'd1);
        checkOutput("t3_empty", 64'(s_empty_n), 64'd0);
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, {$urandom, $urandom}, 1'b1);
            if (s_done) break;
        end
        checkOutput("t3_done", 64'(s_done), 64'd1);
        checkOutput("t3_acc20", 64'(accepted), 64'd20);
        checkOutput("t3_sb", 64'(sb_q.size()), 64'd0);
        applyStimulus(1'b0, 64'd0, 1'b0);

        $display("[TB] lane overflow");
`ifdef MATBI_SCALER_SAT_EN
        sat_exp = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        sat_exp = 64'h0000_0000_0000_0000;
`endif
        startJob(32'd8, 8'd255, 3'd0, 8'd255);
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        waitDone("t4_done", 10);
        checkOutput("t4_lane", popped_q[0], sat_exp);
        applyStimulus(1'b0, 64'd0, 1'b0);

        $display("[TB] concurrency");
        startJob(32'd800, 8'd37, 3'd3, 8'd11);
        n = 0;
        while (accepted < 100 && n < 200) begin
            applyStimulus(1'b1, {$urandom, $urandom}, 1'b1);
            n++;
        end
        checkOutput("t5_cycles", 64'(n), 64'd100);
        checkOutput("t5_occupancy", 64'(max_depth), 64'd3);
        waitDone("t5_done", 10);
        checkOutput("t5_pops", 64'(pops), 64'd100);
        checkOutput("t5_sb", 64'(sb_q.size()), 64'd0);
        applyStimulus(1'b0, 64'd0, 1'b0);

        $display("[TB] mid-job reset");
        startJob(32'd80, 8'd1, 3'd0, 8'd0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, {$urandom, $urandom}, 1'b0);
        checkOutput("t6_acc5", 64'(accepted), 64'd5);
        areset = 1'b1;
        applyStimulus(1'b0, 64'd0, 1'b0);
        areset = 1'b0;
        sb_q.delete();
        applyStimulus(1'b0, 64'd0, 1'b0);
        checkOutput("t6_idle", 64'(s_idle), 64'd1);
        checkOutput("t6_empty_n", 64'(s_empty_n), 64'd0);
        checkOutput("t6_full_n", 64'(s_full_n), 64'd0);
        done_any = s_done;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 64'd0, 1'b1);
            done_any = done_any | s_done;
        end
        checkOutput("t6_no_done", 64'(done_any), 64'd0);
        startJob(32'd8, 8'd4, 3'd1, 8'd1);
        applyStimulus(1'b1, {$urandom, $urandom}, 1'b1);
        waitDone("t6_new_done", 10);
        checkOutput("t6_new_pops", 64'(pops), 64'd1);
        checkOutput("t6_new_sb", 64'(sb_q.size()), 64'd0);
        applyStimulus(1'b0, 64'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
